// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: counting-mode encoding.
package counter_pkg;

   // Two-bit counting mode; the unused encoding 2'b11 behaves as wrap.
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_WRAP    = 2'b00;
   localparam mode_t MODE_SAT     = 2'b01;
   localparam mode_t MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable limit, wrap/saturate/one-shot
// modes, cascade carry and a registered terminal-count pulse.
// Count range is 0..limit. Wider counts are built by chaining carry_out of one
// instance into carry_in of the next.
module counter_updown_mod
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             carry_in,
   input  logic             updown,
   input  logic             load,
   input  logic             set,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] limit,
   input  mode_t            mode,
   output logic [WIDTH-1:0] data_out,
   output logic             carry_out,
   output logic             tc_pulse,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             done_nxt;
   logic             step;
   logic             at_term;

   // Loaded values are never allowed to exceed the current limit.
   function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] value,
                                                       input logic [WIDTH-1:0] lim);
      return (value > lim) ? lim : value;
   endfunction

   // A completed one-shot blocks any further stepping until set/load/reset.
   assign step = enable & carry_in & ~done;

   // ">=" so that a count left above a freshly lowered limit is terminal going up.
   assign at_term = updown ? (count == '0) : (count >= limit);

   // Same-cycle carry lets the next stage step on the edge this stage wraps.
   assign carry_out = step & at_term;

   assign data_out = count;

   // Next-state selection in priority order: set > load > step > hold.
   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      done_nxt  = done;
      if (set) begin
         count_nxt = limit;
         done_nxt  = 1'b0;
      end else if (load) begin
         count_nxt = clamp_to_limit(data, limit);
         done_nxt  = 1'b0;
      end else if (step) begin
         if (!at_term) begin
            count_nxt = updown ? (count - ONE) : (count + ONE);
         end else begin
            tc_nxt = 1'b1;
            case (mode)
               MODE_SAT: begin
                  count_nxt = count;
               end
               MODE_ONESHOT: begin
                  count_nxt = count;
                  done_nxt  = 1'b1;
               end
               default: begin
                  count_nxt = updown ? limit : '0;
               end
            endcase
         end
      end
   end

   // State register; reset has priority over every other control.
   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= RST_COUNT;
         tc_pulse <= 1'b0;
         done     <= 1'b0;
      end else begin
         count    <= count_nxt;
         tc_pulse <= tc_nxt;
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod at WIDTH=4: a vector table for the
// single counter and a two-stage cascade run.
module tb_counter_updown_mod;

   logic       clock;
   logic       reset, enable, carry_in, updown, load, set;
   logic [3:0] data, limit;
   logic [1:0] mode;
   logic [3:0] data_out;
   logic       carry_out, tc_pulse, done;

   logic       c_reset, c_enable;
   logic [3:0] lo_out, hi_out;
   logic       lo_co, hi_co, lo_tc, hi_tc, lo_done, hi_done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       rst, st, ld, en, ci, ud;
      logic [1:0] md;
      logic [3:0] dat, lim;
      logic       e_co;
      logic [3:0] e_cnt;
      logic       e_tc, e_done;
   } vec_t;

   vec_t vecs[$];

   counter_updown_mod #(.WIDTH(4), .RESET_VALUE(3)) dut (
      .clock(clock), .reset(reset), .enable(enable), .carry_in(carry_in),
      .updown(updown), .load(load), .set(set), .data(data), .limit(limit),
      .mode(mode), .data_out(data_out), .carry_out(carry_out),
      .tc_pulse(tc_pulse), .done(done)
   );

   counter_updown_mod #(.WIDTH(4), .RESET_VALUE(0)) lo (
      .clock(clock), .reset(c_reset), .enable(c_enable), .carry_in(1'b1),
      .updown(1'b0), .load(1'b0), .set(1'b0), .data(4'd0), .limit(4'd15),
      .mode(2'b00), .data_out(lo_out), .carry_out(lo_co),
      .tc_pulse(lo_tc), .done(lo_done)
   );

   counter_updown_mod #(.WIDTH(4), .RESET_VALUE(0)) hi (
      .clock(clock), .reset(c_reset), .enable(c_enable), .carry_in(lo_co),
      .updown(1'b0), .load(1'b0), .set(1'b0), .data(4'd0), .limit(4'd15),
      .mode(2'b00), .data_out(hi_out), .carry_out(hi_co),
      .tc_pulse(hi_tc), .done(hi_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, st, ld, en, ci, ud, input logic [1:0] md,
                      input logic [3:0] dat, lim, input logic e_co,
                      input logic [3:0] e_cnt, input logic e_tc, e_done);
      vec_t v;
      v.rst = rst; v.st = st; v.ld = ld; v.en = en; v.ci = ci; v.ud = ud;
      v.md = md; v.dat = dat; v.lim = lim; v.e_co = e_co;
      v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_done = e_done;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; carry_in = 1'b1; updown = 1'b0;
      load = 1'b0; set = 1'b0; data = '0; limit = 4'd9; mode = 2'b00;
      c_reset = 1'b1; c_enable = 1'b0;

      //  rst st ld en ci ud md     dat    lim    co  cnt    tc  done
      // reset, then reset beating set+load
      add(1, 0, 0, 0, 1, 0, 2'd0, 4'd0,  4'd9,  0, 4'd3,  0, 0);
      add(1, 0, 0, 0, 1, 0, 2'd0, 4'd0,  4'd9,  0, 4'd3,  0, 0);
      add(1, 1, 1, 0, 1, 0, 2'd0, 4'd5,  4'd9,  0, 4'd3,  0, 0);
      // wrap up, limit 9
      add(0, 0, 1, 0, 1, 0, 2'd0, 4'd7,  4'd9,  0, 4'd7,  0, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd9,  0, 4'd8,  0, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd9,  0, 4'd9,  0, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd9,  1, 4'd0,  1, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd9,  0, 4'd1,  0, 0);
      add(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  4'd9,  0, 4'd1,  0, 0);
      // wrap down
      add(0, 0, 1, 0, 1, 1, 2'd0, 4'd1,  4'd9,  0, 4'd1,  0, 0);
      add(0, 0, 0, 1, 1, 1, 2'd0, 4'd0,  4'd9,  0, 4'd0,  0, 0);
      add(0, 0, 0, 1, 1, 1, 2'd0, 4'd0,  4'd9,  1, 4'd9,  1, 0);
      add(0, 0, 0, 1, 1, 1, 2'd0, 4'd0,  4'd9,  0, 4'd8,  0, 0);
      // load clamp
      add(0, 0, 1, 0, 1, 0, 2'd0, 4'd12, 4'd9,  0, 4'd9,  0, 0);
      // saturate, limit 5
      add(0, 0, 1, 0, 1, 0, 2'd1, 4'd5,  4'd5,  0, 4'd5,  0, 0);
      add(0, 0, 0, 1, 1, 0, 2'd1, 4'd0,  4'd5,  1, 4'd5,  1, 0);
      add(0, 0, 0, 1, 1, 0, 2'd1, 4'd0,  4'd5,  1, 4'd5,  1, 0);
      add(0, 0, 0, 1, 1, 0, 2'd1, 4'd0,  4'd5,  1, 4'd5,  1, 0);
      add(0, 0, 0, 0, 1, 0, 2'd1, 4'd0,  4'd5,  0, 4'd5,  0, 0);
      // mode 11 behaves as wrap; carry_in low blocks stepping
      add(0, 0, 0, 1, 1, 0, 2'd3, 4'd0,  4'd5,  1, 4'd0,  1, 0);
      add(0, 0, 0, 1, 0, 0, 2'd0, 4'd0,  4'd5,  0, 4'd0,  0, 0);
      // one-shot down, limit 3
      add(0, 0, 1, 0, 1, 1, 2'd2, 4'd2,  4'd3,  0, 4'd2,  0, 0);
      add(0, 0, 0, 1, 1, 1, 2'd2, 4'd0,  4'd3,  0, 4'd1,  0, 0);
      add(0, 0, 0, 1, 1, 1, 2'd2, 4'd0,  4'd3,  0, 4'd0,  0, 0);
      add(0, 0, 0, 1, 1, 1, 2'd2, 4'd0,  4'd3,  1, 4'd0,  1, 1);
      add(0, 0, 0, 1, 1, 1, 2'd2, 4'd0,  4'd3,  0, 4'd0,  0, 1);
      add(0, 0, 0, 1, 1, 1, 2'd2, 4'd0,  4'd3,  0, 4'd0,  0, 1);
      add(0, 0, 0, 1, 1, 1, 2'd0, 4'd0,  4'd3,  0, 4'd0,  0, 1);
      add(0, 1, 0, 0, 1, 1, 2'd0, 4'd0,  4'd3,  0, 4'd3,  0, 0);
      // set beats load
      add(0, 1, 1, 0, 1, 0, 2'd0, 4'd1,  4'd9,  0, 4'd9,  0, 0);
      // limit lowered below count: up wraps, down decrements
      add(0, 0, 1, 0, 1, 0, 2'd0, 4'd8,  4'd9,  0, 4'd8,  0, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd4,  1, 4'd0,  1, 0);
      add(0, 0, 1, 0, 1, 0, 2'd0, 4'd8,  4'd9,  0, 4'd8,  0, 0);
      add(0, 0, 0, 1, 1, 1, 2'd0, 4'd0,  4'd4,  0, 4'd7,  0, 0);
      // limit 0: every step is terminal
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd0,  1, 4'd0,  1, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd0,  1, 4'd0,  1, 0);
      add(0, 0, 0, 1, 1, 1, 2'd0, 4'd0,  4'd0,  1, 4'd0,  1, 0);
      // limit 15: natural binary wrap
      add(0, 0, 1, 0, 1, 0, 2'd0, 4'd15, 4'd15, 0, 4'd15, 0, 0);
      add(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  4'd15, 1, 4'd0,  1, 0);
      // one-shot done cleared by load
      add(0, 0, 0, 1, 1, 1, 2'd2, 4'd0,  4'd3,  1, 4'd0,  1, 1);
      add(0, 0, 1, 0, 1, 1, 2'd2, 4'd2,  4'd3,  0, 4'd2,  0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         reset = vecs[i].rst; set = vecs[i].st; load = vecs[i].ld;
         enable = vecs[i].en; carry_in = vecs[i].ci; updown = vecs[i].ud;
         mode = vecs[i].md; data = vecs[i].dat; limit = vecs[i].lim;
         #1;
         check($sformatf("v%0d carry_out", i), {31'd0, carry_out}, {31'd0, vecs[i].e_co});
         @(posedge clock);
         #1;
         check($sformatf("v%0d data_out", i), {28'd0, data_out}, {28'd0, vecs[i].e_cnt});
         check($sformatf("v%0d tc_pulse", i), {31'd0, tc_pulse}, {31'd0, vecs[i].e_tc});
         check($sformatf("v%0d done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
      end

      // Cascade: 20 enabled cycles from zero, high stage steps on low wrap.
      @(negedge clock);
      c_reset = 1'b1; c_enable = 1'b0;
      @(negedge clock);
      c_reset = 1'b0; c_enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         check($sformatf("cas%0d lo_carry", i), {31'd0, lo_co}, {31'd0, (i % 16) == 15});
         @(posedge clock);
         #1;
         check($sformatf("cas%0d value", i), {24'd0, hi_out, lo_out}, i + 1);
         check($sformatf("cas%0d lo_tc", i), {31'd0, lo_tc}, {31'd0, ((i + 1) % 16) == 0});
         @(negedge clock);
      end
      c_enable = 1'b0;
      #1;
      check("cascade final", {24'd0, hi_out, lo_out}, 32'h14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised up/down counter that generalises the team's fixed 4-bit up/down counter.
- Adds:
  - configurable width;
  - programmable modulus (limit);
  - wrap, saturate and one-shot modes;
  - cascade carry-in/carry-out;
  - registered terminal-count pulse.
- Used as a building block for timers, prescalers and address generators.
- Chains via carry_in/carry_out for wider counts.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- RESET_VALUE, 0, value loaded into count on reset (must be <= 2^WIDTH-1).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable.
- carry_in  in  1  cascade enable; a count step occurs only when enable & carry_in. Tie to 1 for a standalone counter.
- updown  in  1  direction: 0 = up, 1 = down.
- load  in  1  synchronous load of data.
- set  in  1  synchronous preset to limit.
- data  in  WIDTH  load value.
- limit  in  WIDTH  terminal (maximum) value; count range is 0..limit.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- data_out  out  WIDTH  current count (registered).
- carry_out  out  1  combinational cascade carry: enable & carry_in & at_term & ~done.
- tc_pulse  out  1  registered, one-cycle pulse after a step taken at terminal.
- done  out  1  sticky one-shot completion flag (registered).

Behaviour:
- Reset and priority:
  - Priority per rising edge: reset > set > load > step.
  - Reset: data_out = RESET_VALUE, tc_pulse = 0, done = 0.
- Terminal detection:
  - step = enable & carry_in & ~done.
  - at_term = updown ? (count == 0) : (count >= limit).
  - ">=" covers limit being lowered below the current count.
- set:
  - count <= limit; done <= 0; tc_pulse <= 0.
- load:
  - count <= (data > limit) ? limit : data.
  - Loaded value is clamped to limit.
  - done <= 0; tc_pulse <= 0.
- Step, not at terminal:
  - count +1 (up) or -1 (down).
  - tc_pulse <= 0.
- Step at terminal, wrap mode:
  - Up: count <= 0.
  - Down: count <= limit.
  - tc_pulse <= 1.
- Step at terminal, saturate mode:
  - count holds.
  - tc_pulse <= 1 on every step attempted at terminal.
- Step at terminal, one-shot mode:
  - count holds.
  - done <= 1; tc_pulse <= 1.
  - While done = 1:
    - step is suppressed;
    - carry_out = 0;
    - tc_pulse stays 0.
  - done clears only on reset, set or load.
- No step and no set/load:
  - All state holds; tc_pulse <= 0.
- Latency:
  - data_out changes 1 cycle after the qualifying edge.
  - tc_pulse is high the cycle after the terminal step.
  - carry_out is same-cycle combinational, so the upper counter steps on the same edge as the lower counter wraps.
- Width and limit rules:
  - All arithmetic is modulo 2^WIDTH.
  - limit = 0: count pinned at 0; every step is terminal.
  - limit = 2^WIDTH-1: natural binary wrap.
- Mid-run changes:
  - Direction change mid-run takes effect on the next step; no extra state.
  - Mode change mid-run takes effect on the next step.
  - Switching out of one-shot does not clear done.
- Count above limit (e.g. after limit is lowered):
  - Down steps decrement normally.
  - Up steps treat it as terminal.

Decomposition:
- Shared package counter_pkg:
  - mode constants MODE_WRAP = 2'b00, MODE_SAT = 2'b01, MODE_ONESHOT = 2'b10;
  - a 2-bit mode typedef.
- Single module; no sub-module needed.
- Cascading is done by instantiating several counter_updown_mod at top level.

Test Plan:
All scenarios use WIDTH = 4.
- Reset: hold reset 2 cycles with RESET_VALUE=3 → data_out=3, tc_pulse=0, done=0. Assert reset together with set and load → reset wins.
- Wrap up: limit=9, mode=00, up.
  - Load 7, enable 4 cycles → 8, 9, 0, 1.
  - tc_pulse high only in the cycle after 9→0.
  - carry_out high only while count=9 and enabled.
- Wrap down: limit=9, down, load 1, enable 3 cycles → 0, 9, 8.
- Load clamp: limit=9, data=12, load → 9.
- Saturate: limit=5, up, count at 5, enable 3 cycles → holds 5; tc_pulse high on each of the 3 following cycles.
- One-shot: limit=3, mode=10, down.
  - Load 2, enable 5 cycles → 1, 0, 0 with done=1 from the third edge; carry_out=0 thereafter.
  - tc_pulse asserted exactly once.
  - set → count=3, done=0.
- Cascade: two instances, limit=15, low carry_out → high carry_in; run 20 enabled cycles → {high,low} = 0x14, with the high counter stepping on the same edge as the low 15→0 wrap.
- Priority and limit change: assert set and load together → count=limit. Then at count=8 lower limit to 4, step up once → 0 (wrap).
